// File: rtl/eeg_pea_pkg.sv
// Shared types and sizing for the PEA engine output arbiter.
package eeg_pea_pkg;

  localparam int PE_NUM      = 4;
  localparam int DATA_OUT_DW = 8;
  localparam int OMUX_ADD_AW = 8;
  localparam int ORAM_ADD_AW = 10;
  localparam int PE_IDX_AW   = $clog2(PE_NUM);

  // One-hot layer sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_RUN   = 3'b010,
    ST_DRAIN = 3'b100
  } oarb_state_e;

  // Global ORAM address of a PE word: base + pe*stride + local address,
  // wrapping modulo the ORAM address space.
  function automatic logic [ORAM_ADD_AW-1:0] calc_oadd(
    input logic [ORAM_ADD_AW-1:0] base,
    input logic [ORAM_ADD_AW-1:0] stride,
    input logic [PE_IDX_AW-1:0]   idx,
    input logic [OMUX_ADD_AW-1:0] ladd
  );
    logic [ORAM_ADD_AW-1:0] off;
    off = ORAM_ADD_AW'(idx) * stride;
    return base + off + ORAM_ADD_AW'(ladd);
  endfunction

endpackage

// File: rtl/eeg_rr_arb.sv
// Combinational round-robin picker: first requester at or above the
// pointer, wrapping. The pointer register lives in the parent.
module eeg_rr_arb #(
  parameter int N  = 4,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [AW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [AW-1:0] o_idx,
  output logic          o_any
);

  logic          w_found;
  logic [AW-1:0] w_cand;

  // Scan candidates starting at the pointer; N is a power of two, so the
  // AW-bit addition wraps naturally.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = i_ptr + AW'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/eeg_pea_eng_oarb.sv
// Round-robin output arbiter / layer sequencer for a row of PEA PEs.
// Shares one ORAM write port among PE_NUM PE output streams.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for CFG_START; no grants
// ST_RUN   | arbitrating PE outputs until every enabled PE sent its last
// ST_DRAIN | last word issued; waiting for the write stage to empty
module eeg_pea_eng_oarb
  import eeg_pea_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          CFG_START,
  input  logic [PE_NUM-1:0]             CFG_PE_ENA,
  input  logic [ORAM_ADD_AW-1:0]        CFG_OADD_BASE,
  input  logic [ORAM_ADD_AW-1:0]        CFG_OADD_STRIDE,
  output logic                          IS_IDLE,
  output logic                          LAYER_DONE,
  input  logic [PE_NUM-1:0]             PE_OUT_VLD,
  input  logic [PE_NUM-1:0]             PE_OUT_LST,
  input  logic [PE_NUM*OMUX_ADD_AW-1:0] PE_OUT_ADD,
  input  logic [PE_NUM*DATA_OUT_DW-1:0] PE_OUT_DAT,
  output logic [PE_NUM-1:0]             PE_OUT_RDY,
  output logic                          ORAM_WEN,
  output logic [ORAM_ADD_AW-1:0]        ORAM_ADD,
  output logic [DATA_OUT_DW-1:0]        ORAM_DAT,
  input  logic                          ORAM_RDY
);

  oarb_state_e            r_state;
  oarb_state_e            w_state_nxt;
  logic [PE_NUM-1:0]      r_ena;
  logic [ORAM_ADD_AW-1:0] r_base;
  logic [ORAM_ADD_AW-1:0] r_stride;
  logic [PE_NUM-1:0]      r_lst_seen;
  logic [PE_IDX_AW-1:0]   r_ptr;
  logic                   r_wen;
  logic [ORAM_ADD_AW-1:0] r_add;
  logic [DATA_OUT_DW-1:0] r_dat;
  logic                   r_done;
  logic                   w_done_nxt;

  logic                   w_start_ok;
  logic [PE_NUM-1:0]      w_req;
  logic [PE_NUM-1:0]      w_gnt;
  logic [PE_IDX_AW-1:0]   w_idx;
  logic                   w_any;
  logic                   w_stage_free;
  logic                   w_hs;
  logic                   w_hs_lst;
  logic [PE_NUM-1:0]      w_lst_nxt;
  logic [OMUX_ADD_AW-1:0] w_sel_add;
  logic [DATA_OUT_DW-1:0] w_sel_dat;

  assign w_start_ok   = (r_state == ST_IDLE) && CFG_START;
  assign w_stage_free = ~r_wen | ORAM_RDY;

  // Only requests from enabled PEs that have not yet delivered their last
  // word compete, and only while the layer is running.
  assign w_req = (r_state == ST_RUN) ? (PE_OUT_VLD & r_ena & ~r_lst_seen) : '0;

  eeg_rr_arb #(
    .N  (PE_NUM),
    .AW (PE_IDX_AW)
  ) u_rr_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign PE_OUT_RDY = w_stage_free ? w_gnt : '0;
  assign w_hs       = w_any & w_stage_free;
  assign w_hs_lst   = w_hs & PE_OUT_LST[w_idx];
  assign w_lst_nxt  = r_lst_seen | (w_hs_lst ? w_gnt : '0);
  assign w_sel_add  = PE_OUT_ADD[w_idx*OMUX_ADD_AW +: OMUX_ADD_AW];
  assign w_sel_dat  = PE_OUT_DAT[w_idx*DATA_OUT_DW +: DATA_OUT_DW];

  // Next-state and done-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (CFG_START) begin
          if (CFG_PE_ENA == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if ((w_lst_nxt & r_ena) == r_ena) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_wen || ORAM_RDY) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered layer-done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Layer configuration, captured only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena    <= '0;
      r_base   <= '0;
      r_stride <= '0;
    end else if (w_start_ok) begin
      r_ena    <= CFG_PE_ENA;
      r_base   <= CFG_OADD_BASE;
      r_stride <= CFG_OADD_STRIDE;
    end
  end

  // Per-PE last-seen tracking, cleared at each layer start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lst_seen <= '0;
    end else if (w_start_ok) begin
      r_lst_seen <= '0;
    end else begin
      r_lst_seen <= w_lst_nxt;
    end
  end

  // Round-robin pointer: moves past the winner only when a word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_idx + 1'b1;
    end
  end

  // Single-entry write stage; address/data hold while ORAM stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen <= 1'b0;
      r_add <= '0;
      r_dat <= '0;
    end else if (w_hs) begin
      r_wen <= 1'b1;
      r_add <= calc_oadd(r_base, r_stride, w_idx, w_sel_add);
      r_dat <= w_sel_dat;
    end else if (ORAM_RDY) begin
      r_wen <= 1'b0;
    end
  end

  assign IS_IDLE    = (r_state == ST_IDLE);
  assign LAYER_DONE = r_done;
  assign ORAM_WEN   = r_wen;
  assign ORAM_ADD   = r_add;
  assign ORAM_DAT   = r_dat;

endmodule

// File: tb/tb_eeg_pea_eng_oarb.sv
// Scoreboard bench for the PEA output arbiter with a cycle-level reference.
module tb_eeg_pea_eng_oarb;

  localparam int PE = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CFG_START;
  logic [3:0]  CFG_PE_ENA;
  logic [9:0]  CFG_OADD_BASE;
  logic [9:0]  CFG_OADD_STRIDE;
  logic        IS_IDLE;
  logic        LAYER_DONE;
  logic [3:0]  PE_OUT_VLD;
  logic [3:0]  PE_OUT_LST;
  logic [31:0] PE_OUT_ADD;
  logic [31:0] PE_OUT_DAT;
  logic [3:0]  PE_OUT_RDY;
  logic        ORAM_WEN;
  logic [9:0]  ORAM_ADD;
  logic [7:0]  ORAM_DAT;
  logic        ORAM_RDY;

  eeg_pea_eng_oarb dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .CFG_START       (CFG_START),
    .CFG_PE_ENA      (CFG_PE_ENA),
    .CFG_OADD_BASE   (CFG_OADD_BASE),
    .CFG_OADD_STRIDE (CFG_OADD_STRIDE),
    .IS_IDLE         (IS_IDLE),
    .LAYER_DONE      (LAYER_DONE),
    .PE_OUT_VLD      (PE_OUT_VLD),
    .PE_OUT_LST      (PE_OUT_LST),
    .PE_OUT_ADD      (PE_OUT_ADD),
    .PE_OUT_DAT      (PE_OUT_DAT),
    .PE_OUT_RDY      (PE_OUT_RDY),
    .ORAM_WEN        (ORAM_WEN),
    .ORAM_ADD        (ORAM_ADD),
    .ORAM_DAT        (ORAM_DAT),
    .ORAM_RDY        (ORAM_RDY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       l;
  } word_t;

  typedef struct packed {
    logic [9:0] add;
    logic [7:0] dat;
  } exp_t;

  word_t pe_q[PE][$];
  exp_t  sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state (value for the upcoming cycle).
  int m_state;
  int m_ena, m_base, m_stride, m_lst, m_ptr;
  bit m_wen, m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: per cycle, decide who the round-robin rules serve and what
  // the ORAM must eventually see.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = M_IDLE; m_ena = 0; m_base = 0; m_stride = 0;
      m_lst = 0; m_ptr = 0; m_wen = 0; m_done = 0;
      sb_q.delete();
    end else begin
      int  g;
      bit  found, free, nd;
      int  exp_rdy;
      chk("is_idle", IS_IDLE, m_state == M_IDLE);
      chk("layer_done", LAYER_DONE, m_done);
      chk("oram_wen", ORAM_WEN, m_wen);
      free = !m_wen || ORAM_RDY;
      found = 0; g = 0; exp_rdy = 0; nd = 0;
      if (m_state == M_RUN) begin
        for (int k = 0; k < PE; k++) begin
          int p;
          p = (m_ptr + k) % PE;
          if (!found && PE_OUT_VLD[p] && m_ena[p] && !m_lst[p]) begin
            found = 1; g = p;
          end
        end
        if (found && free) exp_rdy = 1 << g;
      end
      chk("pe_out_rdy", PE_OUT_RDY, exp_rdy);
      if (exp_rdy != 0) begin
        exp_t e;
        int   a;
        a = (m_base + g * m_stride + int'(PE_OUT_ADD[g*8 +: 8])) % 1024;
        e.add = a[9:0];
        e.dat = PE_OUT_DAT[g*8 +: 8];
        sb_q.push_back(e);
        m_ptr = (g + 1) % PE;
        if (PE_OUT_LST[g]) m_lst = m_lst | (1 << g);
      end
      m_wen = (exp_rdy != 0) ? 1'b1 : (ORAM_RDY ? 1'b0 : m_wen);
      case (m_state)
        M_IDLE: if (CFG_START) begin
          m_ena = CFG_PE_ENA; m_base = CFG_OADD_BASE; m_stride = CFG_OADD_STRIDE;
          m_lst = 0;
          if (CFG_PE_ENA == 0) nd = 1; else m_state = M_RUN;
        end
        M_RUN: if ((m_lst & m_ena) == m_ena) m_state = M_DRAIN;
        default: if (!free || !m_wen || ORAM_RDY) begin
          // leave DRAIN once the write stage is (or becomes) empty
          if (!(ORAM_WEN && !ORAM_RDY)) begin m_state = M_IDLE; nd = 1; end
        end
      endcase
      m_done = nd;
    end
  end

  // Monitor: every accepted ORAM write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && ORAM_WEN && ORAM_RDY) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", ORAM_ADD, -1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("oram_add", ORAM_ADD, e.add);
        chk("oram_dat", ORAM_DAT, e.dat);
      end
    end
  end

  task automatic push_word(input int p, input int a, input int d, input bit l);
    word_t w;
    w.a = a[7:0]; w.d = d[7:0]; w.l = l;
    pe_q[p].push_back(w);
  endtask

  task automatic fill_rand(input int p, input int n, input int extra);
    for (int i = 0; i < n + extra; i++)
      push_word(p, $urandom_range(0, 255), $urandom, i == n - 1);
  endtask

  task automatic clear_pes();
    for (int p = 0; p < PE; p++) pe_q[p].delete();
    PE_OUT_VLD = '0; PE_OUT_LST = '0; PE_OUT_ADD = '0; PE_OUT_DAT = '0;
  endtask

  task automatic drive_pes(input int gap);
    for (int p = 0; p < PE; p++) begin
      if (pe_q[p].size() == 0) begin
        PE_OUT_VLD[p] = 1'b0;
      end else begin
        if (!PE_OUT_VLD[p]) PE_OUT_VLD[p] = ($urandom_range(0, 99) >= gap);
        PE_OUT_LST[p]        = pe_q[p][0].l;
        PE_OUT_ADD[p*8 +: 8] = pe_q[p][0].a;
        PE_OUT_DAT[p*8 +: 8] = pe_q[p][0].d;
      end
    end
  endtask

  task automatic drive_rdy(input int mode, input int cyc);
    case (mode)
      1:       ORAM_RDY = ($urandom_range(0, 99) < 70);
      2:       ORAM_RDY = !(cyc >= 4 && cyc <= 6);
      default: ORAM_RDY = 1'b1;
    endcase
  endtask

  // Starts a layer in the current cycle and plays PE streams until
  // LAYER_DONE, an ena=0 start, or a mid-layer reset.
  task automatic run_layer(input logic [3:0] ena, input int base, input int stride,
                           input int rdy_mode, input int gap, input int rst_at,
                           input bit noise);
    bit finished;
    finished = 0;
    CFG_START = 1'b1; CFG_PE_ENA = ena;
    CFG_OADD_BASE = base[9:0]; CFG_OADD_STRIDE = stride[9:0];
    drive_pes(gap);
    drive_rdy(rdy_mode, 0);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      logic [3:0] hs;
      bit         done;
      @(negedge clk);
      hs   = PE_OUT_VLD & PE_OUT_RDY;
      done = LAYER_DONE && (cyc > 1);
      @(posedge clk); #1;
      CFG_START = 1'b0;
      if (ena == 4'b0000) return;
      if (cyc == rst_at) begin
        chk("pre_rst_wen", ORAM_WEN, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wen", ORAM_WEN, 0);
        chk("rst_add", ORAM_ADD, 0);
        chk("rst_dat", ORAM_DAT, 0);
        chk("rst_done", LAYER_DONE, 0);
        chk("rst_idle", IS_IDLE, 1);
        chk("rst_rdy", PE_OUT_RDY, 0);
        clear_pes();
        ORAM_RDY = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      for (int p = 0; p < PE; p++)
        if (hs[p]) begin
          void'(pe_q[p].pop_front());
          PE_OUT_VLD[p] = 1'b0;
        end
      if (done) begin finished = 1; break; end
      drive_pes(gap);
      drive_rdy(rdy_mode, cyc);
      if (noise && m_state == M_RUN && $urandom_range(0, 7) == 0) begin
        CFG_START = 1'b1; CFG_PE_ENA = 4'($urandom);
        CFG_OADD_BASE = 10'($urandom); CFG_OADD_STRIDE = 10'($urandom);
      end
    end
    if (!finished) chk("layer_timeout", 0, 1);
    ORAM_RDY = 1'b1;
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; CFG_START = 1'b0; CFG_PE_ENA = '0;
    CFG_OADD_BASE = '0; CFG_OADD_STRIDE = '0; ORAM_RDY = 1'b1;
    clear_pes();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle", IS_IDLE, 1);
    chk("reset_done", LAYER_DONE, 0);
    chk("reset_wen", ORAM_WEN, 0);
    chk("reset_add", ORAM_ADD, 0);
    chk("reset_dat", ORAM_DAT, 0);
    chk("reset_rdy", PE_OUT_RDY, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single PE, addresses 0x100..0x103
    clear_pes();
    for (int i = 0; i < 4; i++) push_word(0, i, $urandom, i == 3);
    run_layer(4'b0001, 'h100, 'h40, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("idle_after_single", IS_IDLE, 1);

    // fairness, all PEs valid continuously; PE2 addr 5 -> 0x185
    clear_pes();
    for (int p = 0; p < PE; p++)
      for (int i = 0; i < 5; i++) push_word(p, 5 + i, $urandom, i == 4);
    run_layer(4'hF, 'h100, 'h40, 0, 0, 0, 0);

    // ORAM backpressure for three cycles mid-stream
    clear_pes();
    for (int p = 0; p < PE; p++) fill_rand(p, 4, 0);
    run_layer(4'hF, 'h200, 'h20, 2, 0, 0, 0);

    // mask and early last
    clear_pes();
    fill_rand(0, 2, 2);
    fill_rand(1, 3, 0);
    fill_rand(2, 6, 0);
    fill_rand(3, 3, 0);
    run_layer(4'b0101, 'h000, 'h80, 1, 20, 0, 0);
    chk("pe0_stalled_words", pe_q[0].size(), 2);
    chk("pe1_untouched", pe_q[1].size(), 3);
    chk("pe3_untouched", pe_q[3].size(), 3);

    // empty mask, then a start coinciding with LAYER_DONE; address wrap
    clear_pes();
    run_layer(4'b0000, 'h123, 'h11, 0, 0, 0, 0);
    clear_pes();
    push_word(3, 'h20, 'h5A, 1'b1);
    run_layer(4'b1000, 'h3F0, 'h10, 0, 0, 0, 0);

    // randomized layers with ignored starts during RUN
    for (int t = 0; t < 8; t++) begin
      logic [3:0] ena;
      clear_pes();
      ena = 4'($urandom_range(1, 15));
      for (int p = 0; p < PE; p++) fill_rand(p, $urandom_range(1, 6), $urandom_range(0, 1));
      run_layer(ena, $urandom_range(0, 1023), $urandom_range(0, 1023), 1, 30, 0, 1);
    end

    // reset in the middle of a busy layer, then a clean layer
    clear_pes();
    for (int p = 0; p < PE; p++) fill_rand(p, 8, 0);
    run_layer(4'hF, 'h100, 'h40, 0, 0, 4, 0);
    clear_pes();
    for (int p = 0; p < PE; p++) fill_rand(p, 3, 0);
    run_layer(4'b0110, 'h050, 'h30, 1, 10, 0, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eeg_pea_eng_oarb.md
Name: eeg_pea_eng_oarb

Overview:
- Round-robin output arbiter and sequencer for a row of PEA engine PEs; shares one output-RAM write port among PE_NUM PEs.
- Accepts each PE's valid/ready output stream (data, local address, last flag) and forms the global ORAM address from per-layer base/stride configuration.
- Signals layer completion once every enabled PE has delivered its last output and the write stage has drained.
- Sits between the PE array and the ORAM bank mux.

Parameters:
- PE_NUM, 4, number of PEs arbitrated (power of two, >=2)
- DATA_OUT_DW, 8, PE output data width
- OMUX_ADD_AW, 8, PE-local output address width
- ORAM_ADD_AW, 10, ORAM address width
- PE_IDX_AW, $clog2(PE_NUM), grant index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CFG_START  in  1  one-cycle layer start pulse
- CFG_PE_ENA  in  PE_NUM  enabled-PE mask, sampled on accepted start
- CFG_OADD_BASE  in  ORAM_ADD_AW  layer base address, sampled on start
- CFG_OADD_STRIDE  in  ORAM_ADD_AW  per-PE address stride, sampled on start
- IS_IDLE  out  1  FSM in IDLE
- LAYER_DONE  out  1  one-cycle completion pulse
- PE_OUT_VLD  in  PE_NUM  per-PE output valid
- PE_OUT_LST  in  PE_NUM  per-PE last-output flag
- PE_OUT_ADD  in  PE_NUM*OMUX_ADD_AW  per-PE local address, packed with PE0 in the LSBs
- PE_OUT_DAT  in  PE_NUM*DATA_OUT_DW  per-PE data, packed
- PE_OUT_RDY  out  PE_NUM  per-PE ready, at most one bit high
- ORAM_WEN  out  1  write valid
- ORAM_ADD  out  ORAM_ADD_AW  write address
- ORAM_DAT  out  DATA_OUT_DW  write data
- ORAM_RDY  in  1  ORAM accepts write (handshake fires on ORAM_WEN&ORAM_RDY)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM=IDLE, IS_IDLE=1.
  - LAYER_DONE=0, ORAM_WEN=0, ORAM_ADD=0, ORAM_DAT=0.
  - Round-robin pointer=0; lst_seen=0; cfg registers=0.
  - PE_OUT_RDY=0, because it is gated by the FSM.
- FSM states are IDLE, RUN, DRAIN.
  - IDLE→RUN on CFG_START. Latch ena mask, base and stride; clear lst_seen.
  - If CFG_PE_ENA==0 on start: go directly IDLE→IDLE and pulse LAYER_DONE the next cycle.
  - RUN→DRAIN when (lst_seen | accepted-lst-this-cycle) covers ena mask.
  - DRAIN→IDLE when ORAM_WEN==0, or when ORAM_WEN&ORAM_RDY occurs. LAYER_DONE pulses high in the cycle after that transition (registered).
  - CFG_START outside IDLE is ignored.
- Arbitration (RUN only):
  - Request vector req = PE_OUT_VLD & ena & ~lst_seen.
  - Grant = first set bit of req searched from the pointer upward, wrapping.
  - Write-stage can load when stage_free = ~ORAM_WEN | ORAM_RDY.
  - PE_OUT_RDY[g] = stage_free & req[g]; all other bits 0. The grant path is combinational from PE_OUT_VLD; no PE_OUT_VLD→PE_OUT_RDY loop back into PE_OUT_VLD is permitted.
  - On a PE handshake the pointer moves to g+1 mod PE_NUM. Otherwise the pointer holds.
- Write stage (1-cycle latency, PE handshake → ORAM_WEN):
  - On a PE handshake: ORAM_WEN<=1, ORAM_DAT<=PE data, ORAM_ADD<=base + g*stride + zero-extended PE address, truncated mod 2^ORAM_ADD_AW (wrap-around permitted, no saturation).
  - Else if ORAM_RDY: ORAM_WEN<=0.
  - ORAM_ADD and ORAM_DAT hold stable while ORAM_WEN=1 and ORAM_RDY=0.
  - Back-to-back: a new PE handshake in the same cycle the ORAM accepts gives full throughput of 1 word/cycle.
- lst_seen[g] sets on a handshake with PE_OUT_LST[g]=1. Once set, PE g gets no further grants this layer; its later valids stall and are not lost.
- Disabled PEs: their PE_OUT_RDY stays 0 and their valids are ignored.
- Simultaneous events:
  - A last handshake that completes the mask moves RUN→DRAIN in the same cycle; that write still issues.
  - CFG_START arriving together with LAYER_DONE is accepted (FSM already IDLE).
- Reset mid-operation: all state returns to reset values immediately; any pending write is dropped.

Decomposition:
- Shared package eeg_pea_pkg: FSM state encoding (one-hot, 3 bits), PE_NUM, DATA_OUT_DW, OMUX_ADD_AW, ORAM_ADD_AW.
- One sub-module: eeg_rr_arb, a parameterised round-robin priority picker with inputs req and pointer and outputs onehot grant and grant index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Single PE: ena=4'b0001, base=0x100, stride=0x40, PE0 sends addr 0..3 with last on 3, ORAM_RDY=1 → ORAM writes 0x100..0x103 one cycle after each handshake; LAYER_DONE pulses exactly once, one cycle after the last write; IS_IDLE=1 thereafter.
- Fairness: ena=4'hF, all four PEs valid continuously, ORAM_RDY=1 → grant order 0,1,2,3,0,...; PE2 addr 5 maps to 0x100+0x80+5=0x185.
- Backpressure: ORAM_RDY low for 3 cycles mid-stream → ORAM_WEN/ADD/DAT frozen; all PE_OUT_RDY=0; no word lost or duplicated (scoreboard count matches).
- Mask and last: ena=4'b0101, PE1 and PE3 valid → never granted; PE0 last early → PE0 further valids stall; done only after PE2 last.
- Corner cases: start with ena=0 → LAYER_DONE one cycle later; base=0x3F0, stride=0x10, PE3 addr 0x20 → ORAM_ADD=0x040 (wrap); CFG_START during RUN ignored.
- Reset: assert rst_n low during RUN with ORAM_WEN=1 → all outputs at reset values asynchronously; a subsequent new layer completes normally.
